// File: rtl/spgd_pkg.sv
// Shared state codes, DAC source codes and output decode helper for the SPGD sequencer.
package spgd_pkg;

    typedef enum logic [3:0] {
        S_STOPPED   = 4'd0,
        S_T_A       = 4'd1,
        S_ADC_A     = 4'd2,
        S_MATH_A    = 4'd3,
        S_JP_WR     = 4'd4,
        S_T_B       = 4'd5,
        S_ADC_B     = 4'd6,
        S_MATH_B    = 4'd7,
        S_JM_WR     = 4'd8,
        S_MATH_C    = 4'd9,
        S_U_WR      = 4'd10,
        S_RNG       = 4'd11,
        S_DU_WR     = 4'd12,
        S_T_C       = 4'd13,
        S_TRIG_WAIT = 4'd14,
        S_ERROR     = 4'd15
    } state_t;

    localparam logic [1:0] DAC_OFF   = 2'b00;
    localparam logic [1:0] DAC_PLUS  = 2'b01;
    localparam logic [1:0] DAC_MINUS = 2'b10;
    localparam logic [1:0] DAC_RNG   = 2'b11;

    // ADC stays enabled from capture through the matching J write.
    function automatic logic adc_en_state(input state_t s);
        return (s == S_ADC_A) || (s == S_MATH_A) || (s == S_JP_WR) ||
               (s == S_ADC_B) || (s == S_MATH_B) || (s == S_JM_WR);
    endfunction

endpackage

// File: rtl/spgd_trig_sync.sv
// Two-flop synchroniser for EXT_TRIG followed by a registered rising-edge pulse.
module spgd_trig_sync (
    input  logic ADC_CLK,
    input  logic RST,
    input  logic EXT_TRIG,
    output logic TRIG_EDGE
);

    logic [2:0] sync;

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            sync      <= 3'b000;
            TRIG_EDGE <= 1'b0;
        end else begin
            sync      <= {sync[1:0], EXT_TRIG};
            TRIG_EDGE <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/spgd_sequencer.sv
// SPGD iteration sequencer: two-/one-sided, internal-period or EXT_TRIG paced.
// SPGD_SEQ_ADC_TIMEOUT_EN adds an ADC_DONE timeout that lands in ERROR.
import spgd_pkg::*;

module spgd_sequencer #(
    parameter int COUNT_WIDTH = 32,
    parameter int ADC_TIME    = 1036,
    parameter int MATH_TIME   = 10,
    parameter int MATH_C_TIME = 40,
    parameter int RNG_TIME    = 100,
    parameter int ADC_TIMEOUT = 4096
) (
    input  logic                   ADC_CLK,
    input  logic                   RST,
    input  logic                   FSM_EN,
    input  logic                   TWO_SIDED,
    input  logic                   TRIG_MODE,
    input  logic                   EXT_TRIG,
    input  logic                   ADC_DONE,
    input  logic [COUNT_WIDTH-1:0] J_TIME,
    output logic                   ADC_EN,
    output logic                   REG_RST,
    output logic                   RNG_CLK,
    output logic                   J_P_WRT,
    output logic                   J_M_WRT,
    output logic                   U_WRT,
    output logic                   DELTA_U_WRT,
    output logic [1:0]             DAC_SEL,
    output logic [3:0]             FSM_STATE,
    output logic [COUNT_WIDTH-1:0] ITER_COUNT,
    output logic                   TRIG_OVR,
    output logic                   ERR
);

    // One extra bit so 2*J_TIME for T_C never overflows.
    localparam int TW = COUNT_WIDTH + 1;
    localparam logic [TW-1:0] ADC_T   = TW'(ADC_TIME);
    localparam logic [TW-1:0] MATH_T  = TW'(MATH_TIME);
    localparam logic [TW-1:0] MATHC_T = TW'(MATH_C_TIME);
    localparam logic [TW-1:0] RNG_T   = TW'(RNG_TIME);
    localparam logic [TW-1:0] TO_T    = TW'(ADC_TIMEOUT);

    function automatic logic [TW-1:0] wait_load(input logic [TW-1:0] w);
        return (w == '0) ? '0 : w - TW'(1);
    endfunction

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_ld;
    logic [TW-1:0] j_ext, j_dbl, w_ta, w_tb, w_tc;
    logic [1:0]    dac_nxt;
    logic          timer_zero, two_sided_q, trig_edge;

    spgd_trig_sync u_trig_sync (
        .ADC_CLK   (ADC_CLK),
        .RST       (RST),
        .EXT_TRIG  (EXT_TRIG),
        .TRIG_EDGE (trig_edge)
    );

    assign timer_zero = (timer == '0);
    assign FSM_STATE  = state;

    always_comb begin
        j_ext = {1'b0, J_TIME};
        j_dbl = {J_TIME, 1'b0};
        w_ta  = (j_ext < ADC_T) ? '0 : j_ext - ADC_T;
        w_tb  = (j_ext < ADC_T + MATHC_T) ? '0 : j_ext - ADC_T - MATHC_T;
        w_tc  = (j_dbl < RNG_T) ? '0 : j_dbl - RNG_T;
    end

    // ADC_EN is the capture request; ADC_DONE is only honoured while in ADC_A/ADC_B
    // and completes the request on the edge it is sampled high, with no backpressure.
    // TRIG_MODE is only consulted at STOPPED exit and DU_WR, which is where it latches.
    always_comb begin
        state_nxt = state;
        case (state)
            S_STOPPED:   state_nxt = TRIG_MODE ? S_TRIG_WAIT : S_T_A;
            S_TRIG_WAIT: if (trig_edge) state_nxt = S_ADC_A;
            S_T_A:       if (timer_zero) state_nxt = S_ADC_A;
            S_ADC_A: begin
                if (ADC_DONE) state_nxt = S_MATH_A;
`ifdef SPGD_SEQ_ADC_TIMEOUT_EN
                else if (timer_zero) state_nxt = S_ERROR;
`endif
            end
            S_MATH_A:    if (timer_zero) state_nxt = S_JP_WR;
            S_JP_WR:     state_nxt = two_sided_q ? S_T_B : S_MATH_C;
            S_T_B:       if (timer_zero) state_nxt = S_ADC_B;
            S_ADC_B: begin
                if (ADC_DONE) state_nxt = S_MATH_B;
`ifdef SPGD_SEQ_ADC_TIMEOUT_EN
                else if (timer_zero) state_nxt = S_ERROR;
`endif
            end
            S_MATH_B:    if (timer_zero) state_nxt = S_JM_WR;
            S_JM_WR:     state_nxt = S_MATH_C;
            S_MATH_C:    if (timer_zero) state_nxt = S_U_WR;
            S_U_WR:      state_nxt = S_RNG;
            S_RNG:       if (timer_zero) state_nxt = S_DU_WR;
            S_DU_WR:     state_nxt = TRIG_MODE ? S_TRIG_WAIT : S_T_C;
            S_T_C:       if (timer_zero) state_nxt = S_T_A;
            S_ERROR:     state_nxt = S_ERROR;
            default:     state_nxt = S_STOPPED;
        endcase
        if (!FSM_EN) state_nxt = S_STOPPED;
    end

    // Load value is W-1 so a state lasts max(W,1) cycles counting down to zero.
    always_comb begin
        case (state_nxt)
            S_T_A:             timer_ld = wait_load(w_ta);
            S_T_B:             timer_ld = wait_load(w_tb);
            S_T_C:             timer_ld = wait_load(w_tc);
            S_MATH_A, S_MATH_B: timer_ld = wait_load(MATH_T);
            S_MATH_C:          timer_ld = wait_load(MATHC_T);
            S_RNG:             timer_ld = wait_load(RNG_T);
            S_ADC_A, S_ADC_B:  timer_ld = wait_load(TO_T);
            default:           timer_ld = '0;
        endcase
    end

    always_comb begin
        case (state_nxt)
            S_T_A, S_ADC_A, S_MATH_A, S_JP_WR:      dac_nxt = DAC_PLUS;
            S_T_B, S_ADC_B, S_MATH_B, S_JM_WR:      dac_nxt = DAC_MINUS;
            S_MATH_C, S_U_WR:                       dac_nxt = two_sided_q ? DAC_MINUS : DAC_PLUS;
            S_RNG, S_DU_WR, S_T_C, S_TRIG_WAIT:     dac_nxt = DAC_RNG;
            default:                                dac_nxt = DAC_OFF;
        endcase
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state       <= S_STOPPED;
            timer       <= '0;
            two_sided_q <= 1'b0;
            ADC_EN      <= 1'b0;
            REG_RST     <= 1'b1;
            RNG_CLK     <= 1'b0;
            J_P_WRT     <= 1'b0;
            J_M_WRT     <= 1'b0;
            U_WRT       <= 1'b0;
            DELTA_U_WRT <= 1'b0;
            DAC_SEL     <= DAC_OFF;
            ITER_COUNT  <= '0;
            TRIG_OVR    <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) timer <= timer_ld;
            else if (!timer_zero)   timer <= timer - TW'(1);
            if ((state == S_STOPPED && state_nxt != S_STOPPED) || state == S_DU_WR)
                two_sided_q <= TWO_SIDED;
            ADC_EN      <= adc_en_state(state_nxt);
            REG_RST     <= (state_nxt == S_STOPPED);
            RNG_CLK     <= (state_nxt == S_RNG) && (state == S_RNG) && !RNG_CLK;
            J_P_WRT     <= (state_nxt == S_JP_WR);
            J_M_WRT     <= (state_nxt == S_JM_WR);
            U_WRT       <= (state_nxt == S_U_WR);
            DELTA_U_WRT <= (state_nxt == S_DU_WR);
            DAC_SEL     <= dac_nxt;
            if (state_nxt == S_STOPPED)    ITER_COUNT <= '0;
            else if (state_nxt == S_DU_WR) ITER_COUNT <= ITER_COUNT + COUNT_WIDTH'(1);
            if (state_nxt == S_STOPPED) TRIG_OVR <= 1'b0;
            else if (trig_edge && state != S_TRIG_WAIT && state != S_STOPPED) TRIG_OVR <= 1'b1;
`ifdef SPGD_SEQ_ADC_TIMEOUT_EN
            ERR <= (state_nxt == S_ERROR);
`else
            ERR <= 1'b0;
`endif
        end
    end

endmodule
